// File: rtl/pfq_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package pfq_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] PFQ_NOP = 32'h0;

  typedef enum logic [1:0] {
    PFQ_IDLE,
    PFQ_BUSY,
    PFQ_DROP
  } pfq_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
  } pfq_entry_t;

  // Word-granular address compare; byte offset bits are don't-care.
  function automatic logic same_word(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b);
    return ((a ^ b) & ~32'h3) == '0;
  endfunction

endpackage

// File: rtl/pfq_mem_if.sv
// Memory read handshake between the prefetch queue (master) and unified memory (slave).
interface pfq_mem_if;
  logic                       mem_req;
  logic [pfq_pkg::WORD_W-1:0] mem_addr;
  logic                       mem_ack;
  logic [pfq_pkg::WORD_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/pfq_fifo.sv
// Circular buffer of {pc, ir} entries with clear and per-entry ir overwrite for store snooping.
module pfq_fifo
  import pfq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  pfq_entry_t              push_entry,
  input  logic                    pop,
  output pfq_entry_t              head,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    snoop_en,
  input  logic [WORD_W-1:0]       snoop_addr,
  input  logic [WORD_W-1:0]       snoop_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  pfq_entry_t     mem_q [DEPTH];
  logic [AW-1:0]  rd_q, wr_q;
  logic [AW:0]    cnt_q;
  logic [DEPTH-1:0] live;

  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = {1'b0, AW'(i) - rd_q} < cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        // The pushed entry already carries any snooped data.
        if (push && wr_q == AW'(i)) begin
          mem_q[i] <= push_entry;
        end else if (snoop_en && live[i] && same_word(mem_q[i].pc, snoop_addr)) begin
          mem_q[i].ir <= snoop_data;
        end
      end
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher feeding IF/ID; flush redirects fetch to a new target.
// Optional store snooping of queued/in-flight words is enabled by defining PFQ_SMC_SNOOP_EN.
module fetch_prefetch_queue
  import pfq_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  pfq_mem_if.master         mem,
  input  logic              flush,
  input  logic [WORD_W-1:0] flush_pc,
  input  logic              take,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_ir,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_pc4,
  input  logic              st_valid,
  input  logic [WORD_W-1:0] st_addr,
  input  logic [WORD_W-1:0] st_data
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  pfq_state_e        state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;

  logic [CW-1:0] count, count_next;
  pfq_entry_t    head, push_entry;
  logic          push, pop, can_issue, snoop_en;

  assign pop  = take && out_valid && !flush;
  assign push = (state_q == PFQ_BUSY) && mem.mem_ack && !flush;

`ifdef PFQ_SMC_SNOOP_EN
  assign snoop_en = st_valid;
  always_comb begin
    push_entry.pc = fetch_pc_q;
    push_entry.ir = (st_valid && same_word(st_addr, fetch_pc_q)) ? st_data : mem.mem_rdata;
  end
`else
  // Stores are not observed; the CPU's own SMC path handles stale words.
  assign snoop_en = st_valid & 1'b0;
  always_comb begin
    push_entry.pc = fetch_pc_q;
    push_entry.ir = mem.mem_rdata;
  end
`endif

  assign count_next = count + CW'(push) - CW'(pop);
  assign can_issue  = count_next < CW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    if (flush) fetch_pc_d = flush_pc & ~32'h3;
    case (state_q)
      PFQ_IDLE: begin
        if (!flush && can_issue) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = PFQ_BUSY;
        end
      end
      PFQ_BUSY: begin
        if (mem.mem_ack) begin
          if (!flush && can_issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            addr_d     = fetch_pc_q + 32'd4;
          end else begin
            if (!flush) fetch_pc_d = fetch_pc_q + 32'd4;
            req_d   = 1'b0;
            state_d = PFQ_IDLE;
          end
        end else if (flush) begin
          state_d = PFQ_DROP;
        end
      end
      PFQ_DROP: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = PFQ_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = PFQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= PFQ_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  pfq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .snoop_en   (snoop_en),
    .snoop_addr (st_addr),
    .snoop_data (st_data)
  );

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  assign out_valid = count != '0;
  assign out_ir    = out_valid ? head.ir : PFQ_NOP;
  assign out_pc    = head.pc;
  assign out_pc4   = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: queue-based reference model plus directed scenarios with literal checks.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        take = 1'b0;
  logic        out_valid;
  logic [31:0] out_ir, out_pc, out_pc4;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;

  pfq_mem_if mif ();

  fetch_prefetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem       (mif),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .take      (take),
    .out_valid (out_valid),
    .out_ir    (out_ir),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: ack after ack_delay waiting cycles, or when forced.
  int   ack_delay = 0;
  logic force_ack = 1'b0;
  initial begin
    int wcnt;
    wcnt = 0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clock);
      #2;
      if (reset || !mif.mem_req) begin
        mif.mem_ack = 1'b0;
        wcnt = 0;
      end else begin
        mif.mem_ack   = (wcnt >= ack_delay) || force_ack;
        mif.mem_rdata = word_of(mif.mem_addr);
        if (mif.mem_ack) wcnt = 0;
        else wcnt++;
      end
    end
  end

  // Reference model: contents of the queue and the single in-flight request.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        mq[$];
  bit          pend, stale;
  logic [31:0] pend_addr, next_pc;
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  initial begin
    ent_t e;
    bit   drop_ack, pop_now;
    forever begin
      @(negedge clock);
      if (reset) begin
        mq.delete();
        pend = 0; stale = 0; pend_addr = '0; next_pc = 32'h0;
        continue;
      end
      chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_ir", out_ir, mq[0].ir);
        chk("out_pc4", out_pc4, mq[0].pc + 32'd4);
      end else begin
        chk("out_ir_nop", out_ir, 32'h0);
      end
      chk("mem_req", {31'b0, mif.mem_req}, {31'b0, pend});
      if (pend) chk("mem_addr", mif.mem_addr, pend_addr);

      if (mif.mem_req && mif.mem_ack) acc_log.push_back(mif.mem_addr);
      if (take && out_valid && !flush) pop_log.push_back(out_pc);

      drop_ack = 0;
      if (flush) begin
        mq.delete();
        next_pc = flush_pc & ~32'h3;
        if (pend && !mif.mem_ack) stale = 1;
        else pend = 0;
      end else begin
        pop_now = take && (mq.size() != 0);
`ifdef PFQ_SMC_SNOOP_EN
        if (st_valid)
          foreach (mq[j]) if (mq[j].pc[31:2] == st_addr[31:2]) mq[j].ir = st_data;
`endif
        if (pop_now) void'(mq.pop_front());
        if (pend && mif.mem_ack) begin
          if (stale) begin
            drop_ack = 1;
          end else begin
            e.pc = pend_addr;
            e.ir = mif.mem_rdata;
`ifdef PFQ_SMC_SNOOP_EN
            if (st_valid && st_addr[31:2] == pend_addr[31:2]) e.ir = st_data;
`endif
            mq.push_back(e);
            next_pc = pend_addr + 32'd4;
          end
          pend = 0;
          stale = 0;
        end
        if (!pend && !drop_ack && mq.size() < DEPTH) begin
          pend = 1;
          stale = 0;
          pend_addr = next_pc;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset(input int delay);
    reset = 1'b1; flush = 1'b0; take = 1'b0; force_ack = 1'b0; st_valid = 1'b0;
    ack_delay = delay;
    cyc(2);
    chk("rst_mem_req", {31'b0, mif.mem_req}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_mem_addr", mif.mem_addr, 32'h0);
    acc_log.delete();
    pop_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input int budget);
    int n;
    n = 0;
    while (!(mif.mem_req && mif.mem_addr == a) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_req_addr", {31'b0, mif.mem_req && mif.mem_addr == a}, 32'h1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      cyc(1);
      n++;
    end
    chk("wait_valid", {31'b0, out_valid}, 32'h1);
  endtask

  initial begin
    // Fill from reset with zero-latency memory and no consumer.
    do_reset(0);
    cyc(1);
    chk("t1_first_req", {31'b0, mif.mem_req}, 32'h1);
    chk("t1_first_addr", mif.mem_addr, 32'h0);
    cyc(6);
    chk("t1_req_drop", {31'b0, mif.mem_req}, 32'h0);
    chk("t1_out_pc", out_pc, 32'h0);
    chk("t1_out_ir", out_ir, 32'h5A5A_0F0F);
    chk("t1_acc_n", acc_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_acc_addr", acc_log[i], 32'(i * 4));

    // Slow memory with a consumer taking every cycle.
    do_reset(3);
    take = 1'b1;
    cyc(20);
    take = 1'b0;
    chk("t2_pop_n_ge3", {31'b0, pop_log.size() >= 3}, 32'h1);
    for (int i = 0; i < 3; i++) chk("t2_pop_pc", pop_log[i], 32'(i * 4));

    // Flush while the request for 0x8 is outstanding.
    do_reset(3);
    wait_req_addr(32'h8, 40);
    flush = 1'b1; flush_pc = 32'h100;
    cyc(1);
    flush = 1'b0;
    chk("t3_drop_hold_req", {31'b0, mif.mem_req}, 32'h1);
    chk("t3_drop_hold_addr", mif.mem_addr, 32'h8);
    chk("t3_empty", {31'b0, out_valid}, 32'h0);
    wait_req_addr(32'h100, 20);
    wait_valid(20);
    chk("t3_head_pc", out_pc, 32'h100);
    chk("t3_head_ir", out_ir, word_of(32'h100));

    // Flush and ack in the same cycle; unaligned target.
    do_reset(1000);
    wait_req_addr(32'h0, 5);
    force_ack = 1'b1; flush = 1'b1; flush_pc = 32'h203;
    cyc(1);
    force_ack = 1'b0; flush = 1'b0;
    chk("t4_idle_req", {31'b0, mif.mem_req}, 32'h0);
    chk("t4_not_queued", {31'b0, out_valid}, 32'h0);
    cyc(1);
    chk("t4_req", {31'b0, mif.mem_req}, 32'h1);
    chk("t4_addr", mif.mem_addr, 32'h200);
    ack_delay = 0;
    cyc(1);
    chk("t4_head_pc", out_pc, 32'h200);

    // Full queue, then take overlapping acks; then fetch_pc wrap.
    do_reset(0);
    cyc(7);
    take = 1'b1;
    cyc(3);
    take = 1'b0;
    cyc(2);
    chk("t5_pop_n", pop_log.size(), 32'd3);
    for (int i = 0; i < 3; i++) chk("t5_pop_pc", pop_log[i], 32'(i * 4));
    chk("t5_head_pc", out_pc, 32'hC);
    flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
    cyc(1);
    flush = 1'b0;
    cyc(7);
    chk("t5_wrap_head", out_pc, 32'hFFFF_FFF8);
    chk("t5_wrap_pc4", out_pc4, 32'hFFFF_FFFC);
    chk("t5_wrap_full", {31'b0, mif.mem_req}, 32'h0);
    take = 1'b1;
    cyc(2);
    take = 1'b0;
    chk("t5_wrap_zero", out_pc, 32'h0);
    chk("t5_wrap_zero4", out_pc4, 32'h4);

    // Store to a queued instruction address.
    do_reset(0);
    cyc(7);
    st_valid = 1'b1; st_addr = 32'hA; st_data = 32'hDEAD_BEEF;
    cyc(1);
    st_valid = 1'b0;
    take = 1'b1;
    cyc(2);
    take = 1'b0;
    chk("t6_head_pc", out_pc, 32'h8);
`ifdef PFQ_SMC_SNOOP_EN
    chk("t6_head_ir", out_ir, 32'hDEAD_BEEF);
`else
    chk("t6_head_ir", out_ir, word_of(32'h8));
`endif
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
